melody_sequencer: RTL and testbench



---
 rtl/melody_seq_pkg.sv | 23 ++
 rtl/melody_tick_gen.sv | 27 ++
 rtl/melody_sequencer.sv | 124 ++++++++++++
 tb/tb_melody_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/melody_seq_pkg.sv
// Shared types and step-word layout for the melody sequencer.
// Field offsets describe the default widths (NOTE_W=6, LEN_W=3): {last, len, note}.
package melody_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int DEF_NOTE_W  = 6;
  localparam int DEF_LEN_W   = 3;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_TEMPO_W = 16;

  localparam int NOTE_LSB = 0;
  localparam int LEN_LSB  = NOTE_LSB + DEF_NOTE_W;
  localparam int LAST_BIT = LEN_LSB + DEF_LEN_W;

  localparam logic [DEF_NOTE_W-1:0] NOTE_REST = '0;

endpackage

// File: rtl/melody_tick_gen.sv
// Tempo divider: counts 0..tempo_div and pulses tick on the terminal count.
module melody_tick_gen #(
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clear,
  input  logic [TEMPO_W-1:0] tempo_div,
  output logic               tick
);

  logic [TEMPO_W-1:0] cnt;

  // A counter already past a lowered tempo_div runs on and wraps naturally at all-ones.
  assign tick = ena && (cnt == tempo_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clear || tick) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Pattern step sequencer feeding the moosic tone generator.
// Optional MELODY_SEQ_TRANSPOSE_EN adds a transpose input applied when a step is fetched.
module melody_sequencer
  import melody_seq_pkg::*;
#(
  parameter int NOTE_W  = DEF_NOTE_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TEMPO_W = DEF_TEMPO_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [TEMPO_W-1:0]        tempo_div,
  output logic [ADDR_W-1:0]         step_addr,
  input  logic [NOTE_W+LEN_W:0]     step_data,
`ifdef MELODY_SEQ_TRANSPOSE_EN
  input  logic [NOTE_W-1:0]         transpose,
`endif
  output logic [NOTE_W-1:0]         note_out,
  output logic                      gate,
  output logic                      busy,
  output logic                      step_done
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_cnt;
  logic              last_q;
  logic              tick;
  logic              tick_clear;
  logic [NOTE_W-1:0] fetch_note;
  logic [NOTE_W-1:0] next_note;
  logic              step_last;

  assign fetch_note = step_data[NOTE_LSB +: NOTE_W];

`ifdef MELODY_SEQ_TRANSPOSE_EN
  logic [NOTE_W-1:0] shifted;
  always_comb begin
    shifted   = fetch_note + transpose;
    next_note = shifted;
    if (fetch_note == NOTE_REST) next_note = NOTE_REST;
    else if (shifted == '0)      next_note = NOTE_W'(1);
  end
`else
  assign next_note = fetch_note;
`endif

  // Counter is held clear outside PLAY/GAP; the wrap on tick gives a fresh count entering GAP.
  assign tick_clear = (state == IDLE) || (state == FETCH);

  melody_tick_gen #(.TEMPO_W(TEMPO_W)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (tick_clear),
    .tempo_div (tempo_div),
    .tick      (tick)
  );

  assign step_last = last_q || (step_addr == '1);
  assign gate      = (state == PLAY) && (note_out != NOTE_REST);
  assign busy      = (state != IDLE);
  assign step_done = (state == GAP) && tick && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_addr <= '0;
      note_out  <= '0;
      len_q     <= '0;
      len_cnt   <= '0;
      last_q    <= 1'b0;
    end else if (ena) begin
      if (stop) begin
        state     <= IDLE;
        step_addr <= '0;
        note_out  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= FETCH;
              step_addr <= '0;
            end
          end
          FETCH: begin
            note_out <= next_note;
            len_q    <= step_data[LEN_LSB +: LEN_W];
            last_q   <= step_data[LAST_BIT];
            len_cnt  <= '0;
            state    <= PLAY;
          end
          PLAY: begin
            if (tick) begin
              if (len_cnt == len_q) state   <= GAP;
              else                  len_cnt <= len_cnt + 1'b1;
            end
          end
          GAP: begin
            if (tick) begin
              if (!step_last) begin
                step_addr <= step_addr + 1'b1;
                state     <= FETCH;
              end else if (loop_en) begin
                step_addr <= '0;
                state     <= FETCH;
              end else begin
                note_out <= '0;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer.
module tb_melody_sequencer;
  import melody_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, stop, loop_en;
  logic [15:0] tempo_div;
  logic [4:0]  step_addr;
  logic [9:0]  step_data;
  logic [5:0]  note_out;
  logic        gate, busy, step_done;
  logic [9:0]  mem [32];
`ifdef MELODY_SEQ_TRANSPOSE_EN
  logic [5:0]  transpose = '0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign step_data = mem[step_addr];

  melody_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .tempo_div (tempo_div),
    .step_addr (step_addr),
    .step_data (step_data),
`ifdef MELODY_SEQ_TRANSPOSE_EN
    .transpose (transpose),
`endif
    .note_out  (note_out),
    .gate      (gate),
    .busy      (busy),
    .step_done (step_done)
  );

  function automatic logic [9:0] mk(input bit last, input int len, input int note);
    logic [9:0] w;
    logic [2:0] l;
    logic [5:0] n;
    l = len[2:0];
    n = note[5:0];
    w = '0;
    w[LAST_BIT] = last;
    w[LEN_LSB +: 3] = l;
    w[NOTE_LSB +: 6] = n;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (step_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", step_addr); end
    checks++; if (note_out !== 6'd0) begin errors++; $display("FAIL reset_note: got %0d expected 0", note_out); end
    checks++; if ({gate, busy, step_done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {gate, busy, step_done}); end
  endtask

  task automatic test_single_step();
    int bad_play, bad_gap;
    clear_mem();
    mem[0] = mk(1, 1, 12);
    tempo_div = 16'd3;
    pulse_start();
    checks++; if ({busy, gate} !== 2'b10) begin errors++; $display("FAIL single_fetch: got busy,gate=%b expected 10", {busy, gate}); end
    bad_play = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (gate !== 1'b1 || note_out !== 6'd12 || step_done !== 1'b0) bad_play++;
    end
    checks++; if (bad_play !== 0) begin errors++; $display("FAIL single_play: got %0d bad cycles expected 0", bad_play); end
    bad_gap = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (gate !== 1'b0 || busy !== 1'b1 || step_done !== (i == 3)) bad_gap++;
    end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL single_gap: got %0d bad cycles expected 0", bad_gap); end
    step();
    checks++; if ({busy, step_done, note_out} !== 8'd0) begin errors++; $display("FAIL single_idle: got busy=%b done=%b note=%0d expected 0 0 0", busy, step_done, note_out); end
  endtask

  task automatic test_rest();
    logic [6:0] g;
    clear_mem();
    mem[0] = mk(0, 0, 0);
    mem[1] = mk(1, 0, 5);
    tempo_div = 16'd0;
    pulse_start();
    g = '0;
    g[0] = gate;
    for (int i = 1; i < 7; i++) begin
      step();
      g[i] = gate;
      if (i == 4) begin
        checks++; if (note_out !== 6'd5) begin errors++; $display("FAIL rest_note: got %0d expected 5", note_out); end
      end
    end
    checks++; if (g !== 7'b0010000) begin errors++; $display("FAIL rest_gate: got %b expected 0010000", g); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rest_end: got busy=%b expected 0", busy); end
  endtask

  task automatic test_loop();
    int bad_addr, bad_busy;
    clear_mem();
    mem[0] = mk(0, 0, 1);
    mem[1] = mk(0, 0, 2);
    mem[2] = mk(1, 0, 3);
    tempo_div = 16'd0;
    loop_en = 1'b1;
    pulse_start();
    bad_addr = 0;
    bad_busy = 0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) step();
      if (int'(step_addr) != (i / 3) % 3) bad_addr++;
      if (busy !== 1'b1) bad_busy++;
    end
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL loop_addr: got %0d bad cycles expected 0", bad_addr); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL loop_busy: got %0d idle cycles expected 0", bad_busy); end
    loop_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop: got busy=%b expected 0", busy); end
  endtask

  task automatic test_addr_wrap();
    int cycles, dones;
    clear_mem();
    tempo_div = 16'd0;
    loop_en = 1'b0;
    pulse_start();
    cycles = 0;
    dones = 0;
    while (busy === 1'b1 && cycles < 200) begin
      if (step_done === 1'b1) dones++;
      step();
      cycles++;
    end
    checks++; if (cycles !== 96) begin errors++; $display("FAIL wrap_cycles: got %0d expected 96", cycles); end
    checks++; if (dones !== 32) begin errors++; $display("FAIL wrap_steps: got %0d expected 32", dones); end
  endtask

  task automatic test_abort();
    clear_mem();
    mem[0] = mk(1, 3, 9);
    tempo_div = 16'd2;
    pulse_start();
    step();
    step();
    step();
    checks++; if ({gate, note_out} !== {1'b1, 6'd9}) begin errors++; $display("FAIL abort_pre: got gate=%b note=%0d expected 1 9", gate, note_out); end
    stop = 1'b1;
    start = 1'b1;
    step();
    checks++; if ({gate, busy, step_done, step_addr, note_out} !== 14'd0) begin errors++; $display("FAIL abort_state: got gate=%b busy=%b done=%b addr=%0d note=%0d expected all 0", gate, busy, step_done, step_addr, note_out); end
    step();
    stop = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stop_wins: got busy=%b expected 0", busy); end
    step();
  endtask

  task automatic test_freeze_reset();
    int gcnt;
    clear_mem();
    mem[0] = mk(1, 1, 7);
    tempo_div = 16'd1;
    pulse_start();
    gcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (k == 2)  ena = 1'b0;
      if (k == 12) ena = 1'b1;
      step();
      if (gate === 1'b1) gcnt++;
    end
    checks++; if (gcnt !== 14) begin errors++; $display("FAIL freeze_len: got %0d gate cycles expected 14", gcnt); end
    checks++; if ({busy, gate} !== 2'b10) begin errors++; $display("FAIL freeze_gap: got busy,gate=%b expected 10", {busy, gate}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({gate, busy, step_done, step_addr, note_out} !== 14'd0) begin errors++; $display("FAIL async_reset: got gate=%b busy=%b done=%b addr=%0d note=%0d expected all 0", gate, busy, step_done, step_addr, note_out); end
    #2;
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release: got busy=%b expected 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    tempo_div = '0;
    clear_mem();
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_single_step();
    test_rest();
    test_loop();
    test_addr_wrap();
    test_abort();
    test_freeze_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
